pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter sequencer for the ez8 core: fetch address, branch/call/return
//  redirect, skip, squash (kill) of in-flight fetches, and a hardware call stack.
//  Successor to the fixed 12-bit single-interrupt controller: adds configurable PC width and
//  stack depth, NUM_IRQ prioritised vectored interrupts, reti, and under/overflow error codes.
//  Sits between the fetch stage (drives pc_out) and the execute stage (issues goto/call/ret/skip).
// PARAMETERS
//  PC_WIDTH      12  program address width
//  STACK_DEPTH   8   call-stack entries, shared by calls and interrupts; >=2
//  NUM_IRQ       4   interrupt request lines; >=1
//  RESET_VECTOR  0   pc after reset
//  VECTOR_BASE   4   address of the irq[0] handler
//  VECTOR_STRIDE 4   address spacing between handler vectors
// PORTS
//  clk          in  1           clock, all state on rising edge
//  reset        in  1           asynchronous, active-high
//  pause        in  1           hold all state; pulse outputs low while high
//  goto         in  1           execute-stage branch to goto_addr
//  goto_addr    in  PC_WIDTH    branch target
//  call         in  1           with goto: push return address
//  skip         in  1           skip the next instruction
//  ret          in  1           return from subroutine
//  reti         in  1           return from interrupt handler
//  irq          in  NUM_IRQ     level requests, held by source until irq_ack
//  irq_enable   in  1           global interrupt enable
//  irq_ack      out NUM_IRQ     one-hot 1-cycle pulse: request taken
//  save_accum   out 1           1-cycle pulse on handler entry
//  restore_accum out 1          1-cycle pulse on reti
//  pc_out       out PC_WIDTH    fetch address
//  kill         out 1           squash instruction currently issued
//  stack_level  out $clog2(STACK_DEPTH+1)  occupied stack entries
//  error        out 1           sticky fault
//  error_code   out 2           0 none, 1 stack overflow, 2 reti underflow, 3 reti outside ISR
//  stopped      out 1           sticky halt; only reset clears
// BEHAVIOUR
//  - Reset (async): pc=RESET_VECTOR, kill_shift=2'b11 (kill high), stack empty, in_isr=0,
//    state RUN, error=0, error_code=0, stopped=0, all pulses 0.
//  - kill = kill_shift[1]. goto/call/ret/reti qualify only if !kill_shift[0]; skip only if
//    !kill_shift[1]. Unqualified controls are ignored.
//  - RUN priority per cycle (first match wins):
//    1 skip     : pc<=pc+1, kill_shift<=2'b10.
//    2 goto     : pc<=goto_addr; if call push pc (= call addr+1); kill_shift<={ks[0],1}.
//    3 ret      : stack non-empty -> pop into pc; empty -> state STOP_WAIT (program exit).
//    4 reti     : !in_isr -> fault code 3; empty -> fault code 2; else pop into pc, in_isr<=0,
//                 restore_accum pulse. kill_shift<={ks[0],1} for ret and reti.
//    5 irq take : irq_enable && !in_isr && |irq: idx = lowest set bit; push pc-1 (squashed
//                 decode-slot instruction); pc<=VECTOR_BASE+idx*VECTOR_STRIDE (truncated to
//                 PC_WIDTH); in_isr<=1; irq_ack[idx], save_accum pulse; kill_shift<=2'b11.
//    6 else     : pc<=pc+1, kill_shift<={ks[0],0}.
//  - Interrupt is never taken in a cycle with a qualified control (deferred, not lost).
//    Interrupts do not nest; requests arriving while in_isr wait for reti.
//  - Push when stack_level==STACK_DEPTH: fault code 1, no push. Fault: error=1, stopped=1,
//    error_code latched (first fault wins), pc frozen.
//  - STOP_WAIT: one cycle with kill_shift<={ks[0],1}, then stopped=1 (error stays 0).
//  - Push and pop in the same cycle cannot occur. pc arithmetic wraps modulo 2^PC_WIDTH.
//  - pause or stopped: no state changes; irq_ack/save_accum/restore_accum forced low.
//  - Reset asserted mid-operation: immediate return to reset values; stack contents discarded.
// STRUCTURE
//  - Shared include pc_seq_defs.vh: state encoding (RUN, STOP_WAIT, HALT), ERR_* codes.
//  - One sub-module: call_stack (PARAM width/depth; push, pop, top, level, full, empty;
//    async reset; top valid combinationally in the same cycle).
//  - Priority encoder for irq and vector arithmetic are local functions.
// TESTING
//  1 Reset, run 5 cycles -> pc_out 0..4, kill high first 2 cycles only.
//  2 call goto_addr=0x100 at pc=0x011 -> stack top 0x011, pc 0x100, kill 2 cycles; ret -> pc 0x011.
//  3 irq=4'b0110, irq_enable=1, pc=0x020 -> irq_ack=0010, save_accum, pc=0x008, pushed 0x01F;
//    reti -> pc 0x01F, restore_accum, then irq_ack=0100.
//  4 STACK_DEPTH+1 nested calls -> error=1, error_code=1, stopped=1, pc frozen.
//  5 ret with empty stack -> one cycle, then stopped=1, error=0; reti outside ISR -> error_code=3.
//  6 irq with concurrent qualified goto -> branch taken first, interrupt next cycle;
//    pause held 3 cycles mid-sequence -> state and pc unchanged, no pulses.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
//   Shared definitions for the program-counter sequencer: the sequencer
//   state encoding and the fault codes reported on error_code.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_STOP_WAIT = 2'd1,   // program exited via ret on an empty stack
        ST_HALT      = 2'd2
    } seq_state_t;

    localparam logic [1:0] ERR_NONE        = 2'd0;
    localparam logic [1:0] ERR_OVERFLOW    = 2'd1;  // push onto a full stack
    localparam logic [1:0] ERR_RETI_UNDER  = 2'd2;  // reti with nothing to pop
    localparam logic [1:0] ERR_RETI_NO_ISR = 2'd3;  // reti outside a handler

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//   Bundles the execute-stage controls and the sequencer outputs.
//   master : execute stage / interrupt sources (drives controls, irq)
//   slave  : pc_sequencer (drives pc_out, kill, pulses, status)
//   Controls : pause, goto, goto_addr, call, skip, ret, reti, irq, irq_enable
//   Outputs  : irq_ack, save_accum, restore_accum, pc_out, kill,
//              stack_level, error, error_code, stopped
interface pc_sequencer_if #(
    parameter int PC_WIDTH    = 12,
    parameter int STACK_DEPTH = 8,
    parameter int NUM_IRQ     = 4
);
    logic                             pause;
    logic                             goto;
    logic [PC_WIDTH-1:0]              goto_addr;
    logic                             call;
    logic                             skip;
    logic                             ret;
    logic                             reti;
    logic [NUM_IRQ-1:0]               irq;
    logic                             irq_enable;
    logic [NUM_IRQ-1:0]               irq_ack;
    logic                             save_accum;
    logic                             restore_accum;
    logic [PC_WIDTH-1:0]              pc_out;
    logic                             kill;
    logic [$clog2(STACK_DEPTH+1)-1:0] stack_level;
    logic                             error;
    logic [1:0]                       error_code;
    logic                             stopped;

    modport master (
        output pause, goto, goto_addr, call, skip, ret, reti, irq, irq_enable,
        input  irq_ack, save_accum, restore_accum, pc_out, kill,
               stack_level, error, error_code, stopped
    );

    modport slave (
        input  pause, goto, goto_addr, call, skip, ret, reti, irq, irq_enable,
        output irq_ack, save_accum, restore_accum, pc_out, kill,
               stack_level, error, error_code, stopped
    );
endinterface

// File: rtl/pc_sequencer_call_stack.sv
// call_stack
//   LIFO of return addresses shared by calls and interrupts.
//   clk, reset     : clock, async active-high reset (empties the stack)
//   push/push_data : write push_data on top (ignored when full)
//   pop            : drop the top entry (ignored when empty)
//   top            : current top entry, valid combinationally; 0 when empty
//   level          : occupied entries; full / empty flags
module call_stack #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             push_data,
    output logic [WIDTH-1:0]             top,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    lvl;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign wr_idx = lvl[AW-1:0];
    assign rd_idx = AW'(lvl - 1'b1);
    assign full   = (lvl == LW'(DEPTH));
    assign empty  = (lvl == '0);
    assign top    = empty ? '0 : mem[rd_idx];
    assign level  = lvl;

    // Contents need no reset: entries above level are never read.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_idx] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl <= '0;
        end else if (push && !full) begin
            lvl <= lvl + 1'b1;
        end else if (pop && !empty) begin
            lvl <= lvl - 1'b1;
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter sequencer: sequential fetch, branch/call/return redirect,
//   skip, squash of in-flight fetches, vectored prioritised interrupts with
//   reti, and a hardware call stack with sticky fault reporting.
//   clk, reset : clock, async active-high reset
//   bus        : pc_sequencer_if slave (controls in; pc_out, kill, pulses,
//                stack_level, error, error_code, stopped out)
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int PC_WIDTH      = 12,
    parameter int STACK_DEPTH   = 8,
    parameter int NUM_IRQ       = 4,
    parameter int RESET_VECTOR  = 0,
    parameter int VECTOR_BASE   = 4,
    parameter int VECTOR_STRIDE = 4
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);
    localparam int LW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    // Lowest-numbered request has the highest priority.
    function automatic logic [IW-1:0] lowest_irq(input logic [NUM_IRQ-1:0] req);
        lowest_irq = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) lowest_irq = IW'(i);
        end
    endfunction

    function automatic logic [PC_WIDTH-1:0] vector_addr(input logic [IW-1:0] idx);
        return PC_WIDTH'(VECTOR_BASE + int'(idx) * VECTOR_STRIDE);
    endfunction

    seq_state_t          state;
    logic [PC_WIDTH-1:0] pc;
    logic [1:0]          ks;        // kill shift: [1] squashes the issued slot
    logic                in_isr;
    logic                error;
    logic [1:0]          err_code;
    logic                stopped;
    logic [NUM_IRQ-1:0]  ack_q;
    logic                save_q;
    logic                rest_q;

    logic [PC_WIDTH-1:0] stk_top;
    logic [PC_WIDTH-1:0] stk_push_data;
    logic [LW-1:0]       stk_level;
    logic                stk_full, stk_empty, stk_push, stk_pop;

    logic                run;
    logic                q_skip, q_goto, q_ret, q_reti;
    logic                do_skip, do_goto, do_ret, do_reti, do_irq, do_seq;
    logic                push_req, overflow, reti_fault;
    logic [IW-1:0]       irq_idx;

    // Controls from a slot that is being squashed are ignored; skip looks one
    // stage further because it acts on the instruction after the issued one.
    assign run    = !bus.pause && !stopped && (state == ST_RUN);
    assign q_skip = bus.skip && !ks[1];
    assign q_goto = bus.goto && !ks[0];
    assign q_ret  = bus.ret  && !ks[0];
    assign q_reti = bus.reti && !ks[0];
    assign irq_idx = lowest_irq(bus.irq);

    always_comb begin
        do_skip = 1'b0;
        do_goto = 1'b0;
        do_ret  = 1'b0;
        do_reti = 1'b0;
        do_irq  = 1'b0;
        do_seq  = 1'b0;
        if (run) begin
            if (q_skip)                                         do_skip = 1'b1;
            else if (q_goto)                                    do_goto = 1'b1;
            else if (q_ret)                                     do_ret  = 1'b1;
            else if (q_reti)                                    do_reti = 1'b1;
            else if (bus.irq_enable && !in_isr && (|bus.irq))   do_irq  = 1'b1;
            else                                                do_seq  = 1'b1;
        end
    end

    // An interrupt returns to pc-1: the instruction sitting in decode is
    // squashed by the entry and must be re-fetched.
    assign push_req      = (do_goto && bus.call) || do_irq;
    assign overflow      = push_req && stk_full;
    assign stk_push      = push_req && !stk_full;
    assign stk_push_data = do_irq ? pc - 1'b1 : pc;
    assign reti_fault    = do_reti && (!in_isr || stk_empty);
    assign stk_pop       = (do_ret && !stk_empty) || (do_reti && !reti_fault);

    call_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (stk_push_data),
        .top       (stk_top),
        .level     (stk_level),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_RUN;
            pc       <= PC_WIDTH'(RESET_VECTOR);
            ks       <= 2'b11;
            in_isr   <= 1'b0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
            stopped  <= 1'b0;
            ack_q    <= '0;
            save_q   <= 1'b0;
            rest_q   <= 1'b0;
        end else begin
            ack_q  <= '0;
            save_q <= 1'b0;
            rest_q <= 1'b0;
            if (!bus.pause && !stopped) begin
                case (state)
                    ST_RUN: begin
                        if (overflow || reti_fault) begin
                            // Fault freezes pc; stopped blocks any later fault.
                            error   <= 1'b1;
                            stopped <= 1'b1;
                            state   <= ST_HALT;
                            if (overflow)     err_code <= ERR_OVERFLOW;
                            else if (!in_isr) err_code <= ERR_RETI_NO_ISR;
                            else              err_code <= ERR_RETI_UNDER;
                        end else if (do_skip) begin
                            pc <= pc + 1'b1;
                            ks <= 2'b10;
                        end else if (do_goto) begin
                            pc <= bus.goto_addr;
                            ks <= {ks[0], 1'b1};
                        end else if (do_ret) begin
                            if (stk_empty) state <= ST_STOP_WAIT;
                            else           pc    <= stk_top;
                            ks <= {ks[0], 1'b1};
                        end else if (do_reti) begin
                            pc     <= stk_top;
                            in_isr <= 1'b0;
                            rest_q <= 1'b1;
                            ks     <= {ks[0], 1'b1};
                        end else if (do_irq) begin
                            pc     <= vector_addr(irq_idx);
                            in_isr <= 1'b1;
                            ack_q  <= NUM_IRQ'(1) << irq_idx;
                            save_q <= 1'b1;
                            ks     <= 2'b11;
                        end else if (do_seq) begin
                            pc <= pc + 1'b1;
                            ks <= {ks[0], 1'b0};
                        end
                    end
                    ST_STOP_WAIT: begin
                        ks      <= {ks[0], 1'b1};
                        stopped <= 1'b1;
                        state   <= ST_HALT;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.pc_out        = pc;
    assign bus.kill          = ks[1];
    assign bus.stack_level   = stk_level;
    assign bus.error         = error;
    assign bus.error_code    = err_code;
    assign bus.stopped       = stopped;
    assign bus.irq_ack       = bus.pause ? '0 : ack_q;
    assign bus.save_accum    = save_q && !bus.pause;
    assign bus.restore_accum = rest_q && !bus.pause;
endmodule
